// File: rtl/alu_mips_pkg.sv
// ------------------------------------------------------------------------
// alu_mips_pkg: opcodes, handshake states and helpers for alu_mips_md. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package alu_mips_pkg;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLL   = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_NOR   = 5'b01010;
  localparam logic [4:0] OP_SRL   = 5'b10000;
  localparam logic [4:0] OP_SRA   = 5'b10001;
  localparam logic [4:0] OP_SLT   = 5'b10010;
  localparam logic [4:0] OP_SLTU  = 5'b10011;
  localparam logic [4:0] OP_MULT  = 5'b10100;
  localparam logic [4:0] OP_MULTU = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10110;
  localparam logic [4:0] OP_DIVU  = 5'b10111;
  localparam logic [4:0] OP_MFHI  = 5'b11000;
  localparam logic [4:0] OP_MFLO  = 5'b11001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // MULT, MULTU, DIV and DIVU share the 101xx code space.
  function automatic logic is_muldiv(input logic [4:0] control);
    return control[4:2] == 3'b101;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mips_mdcore.sv
// ------------------------------------------------------------------------
// alu_mips_mdcore: 1 bit/cycle shift-add multiplier and restoring divider
// (divider enabled by ALU_MD_DIV_EN). Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module alu_mips_mdcore
  import alu_mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             fin_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;

  logic             is_div, is_sgn, a_neg, b_neg, dz;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge;
  logic [W2-1:0]    step, prod;

`ifdef ALU_MD_DIV_EN
  assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif

  assign is_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg  = is_sgn & a_i[WIDTH-1];
  assign b_neg  = is_sgn & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign dz     = is_div && (b_i == '0);

  // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  // Divide: acc = {remainder, quotient}; shift left, restore-subtract.
  assign div_sh  = acc_q[W2-1:WIDTH-1];
  assign div_ge  = div_sh >= {1'b0, m_q};
  assign div_rem = div_ge ? (div_sh[WIDTH-1:0] - m_q) : div_sh[WIDTH-1:0];

  assign step = div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                      : {mul_sum, acc_q[WIDTH-1:1]};
  assign prod = negq_q ? -step : step;

  always_comb begin
    if (div_q) begin
      lo_o = negq_q ? -step[WIDTH-1:0]  : step[WIDTH-1:0];
      hi_o = negr_q ? -step[W2-1:WIDTH] : step[W2-1:WIDTH];
    end else begin
      lo_o = prod[WIDTH-1:0];
      hi_o = prod[W2-1:WIDTH];
    end
  end

  assign fin_o  = (cnt_q == CW'(1));
  assign div0_o = dz_q;

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    m_d    = m_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    if (load_i) begin
      cnt_d = CW'(WIDTH);
      div_d = is_div;
      dz_d  = dz;
      if (is_div) begin
        // A zero divisor runs on the raw dividend unsigned: quotient fills
        // with ones and the remainder ends up as the raw dividend.
        m_d    = b_mag;
        acc_d  = {{WIDTH{1'b0}}, (dz ? a_i : a_mag)};
        negq_d = ~dz & (a_neg ^ b_neg);
        negr_d = ~dz & a_neg;
      end else begin
        m_d    = a_mag;
        acc_d  = {{WIDTH{1'b0}}, b_mag};
        negq_d = a_neg ^ b_neg;
        negr_d = 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      m_q    <= m_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mips_md.sv
// ------------------------------------------------------------------------
// alu_mips_md: MIPS ALU with HI/LO and iterative MULT/DIV; DIV/DIVU only
// when ALU_MD_DIV_EN is defined. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module alu_mips_md
  import alu_mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       control,
  input  logic [SHW-1:0]   shift,
  input  logic             start,
  output logic [WIDTH-1:0] outalu,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div0_q;

  logic             op_ok, accept, fin, core_div0;
  logic [WIDTH-1:0] core_hi, core_lo, sum, diff;

`ifdef ALU_MD_DIV_EN
  assign op_ok = is_muldiv(control);
`else
  assign op_ok = (control == OP_MULT) || (control == OP_MULTU);
`endif

  assign accept = start && (state_q == ST_IDLE) && op_ok;

  alu_mips_mdcore #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .op_i   (control),
    .a_i    (a),
    .b_i    (b),
    .fin_o  (fin),
    .hi_o   (core_hi),
    .lo_o   (core_lo),
    .div0_o (core_div0)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    outalu = '0;
    ovf    = 1'b0;
    case (control)
      OP_AND:  outalu = a & b;
      OP_OR:   outalu = a | b;
      OP_XOR:  outalu = a ^ b;
      OP_NOR:  outalu = ~(a | b);
      OP_ADD: begin
        outalu = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        outalu = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  outalu = b << shift;
      OP_SRL:  outalu = b >> shift;
      OP_SRA:  outalu = $unsigned($signed(b) >>> shift);
      OP_SLT:  outalu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: outalu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: outalu = hi_q;
      OP_MFLO: outalu = lo_q;
      default: outalu = '0;
    endcase
  end

  assign zero = (outalu == '0);

  always_comb begin
    state_d = state_q;
    if (accept)   state_d = ST_RUN;
    else if (fin) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (fin) begin
        hi_q <= core_hi;
        lo_q <= core_lo;
      end
      if (accept)   div0_q <= 1'b0;
      else if (fin) div0_q <= core_div0;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign div0 = div0_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mips_md.sv
// ------------------------------------------------------------------------
// tb_alu_mips_md: directed self-checking bench for alu_mips_md (WIDTH=32),
// covering both ALU_MD_DIV_EN builds. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_alu_mips_md;

  localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010;
  localparam logic [4:0] C_SUB = 5'b00110, C_SLL = 5'b00111, C_XOR = 5'b01001;
  localparam logic [4:0] C_NOR = 5'b01010, C_SRL = 5'b10000, C_SRA = 5'b10001;
  localparam logic [4:0] C_SLT = 5'b10010, C_SLTU = 5'b10011;
  localparam logic [4:0] C_MULT = 5'b10100, C_MULTU = 5'b10101;
  localparam logic [4:0] C_DIV = 5'b10110, C_DIVU = 5'b10111;
  localparam logic [4:0] C_MFHI = 5'b11000, C_MFLO = 5'b11001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [4:0]  control;
  logic [4:0]  shift;
  logic        start;
  logic [31:0] outalu;
  logic        zero, ovf, busy, done, div0;

  int n_checks = 0;
  int n_errors = 0;

  alu_mips_md #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .control (control),
    .shift   (shift),
    .start   (start),
    .outalu  (outalu),
    .zero    (zero),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [4:0] ctl, input logic [31:0] ra, input logic [31:0] rb,
                     input logic [4:0] sh);
    control = ctl; a = ra; b = rb; shift = sh;
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] ctl, input logic [31:0] exp);
    control = ctl;
    #1;
    check(tag, outalu, exp);
  endtask

  // Issue one op, scramble inputs afterwards, probe MFHI mid-run, wait for done.
  task automatic run_op(input logic [4:0] ctl, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] prev_hi, output int lat);
    a = ra; b = rb; control = ctl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0; control = C_MFHI;
    check("busy_e0", busy, 1);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 5) check("mfhi_run", outalu, prev_hi);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 32);
    check("busy_done", busy, 0);
  endtask

  int lat, cnt_done, cnt_busy;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; control = C_AND; shift = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    rd("rst_hi", C_MFHI, 32'h0);
    rd("rst_lo", C_MFLO, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Combinational path
    alu(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check("add_out", outalu, 32'h8000_0000); check("add_ovf", ovf, 1); check("add_zero", zero, 0);
    alu(C_SUB, 32'd5, 32'd5, 5'd0);
    check("sub_out", outalu, 32'h0); check("sub_zero", zero, 1); check("sub_ovf", ovf, 0);
    alu(C_SUB, 32'h8000_0000, 32'h1, 5'd0);
    check("subov_out", outalu, 32'h7FFF_FFFF); check("subov_ovf", ovf, 1);
    alu(C_SRA, 32'h0, 32'h8000_0000, 5'd4); check("sra", outalu, 32'hF800_0000);
    alu(C_SRL, 32'h0, 32'h8000_0000, 5'd4); check("srl", outalu, 32'h0800_0000);
    alu(C_SLL, 32'h0, 32'h8000_0000, 5'd4); check("sll", outalu, 32'h0); check("sll_zero", zero, 1);
    alu(C_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0); check("slt", outalu, 32'h1);
    alu(C_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0); check("sltu", outalu, 32'h0);
    alu(C_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0); check("xor", outalu, 32'hFF00_FF00);
    alu(C_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0); check("nor", outalu, 32'h000F_000F);
    alu(C_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0); check("or", outalu, 32'hFFF0_FFF0);
    alu(C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0); check("and", outalu, 32'h00F0_00F0);
    alu(C_ADD, 32'h8000_0000, 32'h1, 5'd0); check("add_noovf", ovf, 0);
    alu(C_MULT, 32'h5, 32'h7, 5'd0); check("mult_out0", outalu, 32'h0);
    alu(5'b11111, 32'h5, 32'h7, 5'd0); check("unlisted", outalu, 32'h0);

    // Start with a non-multi-cycle code is ignored
    control = C_ADD; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_add_busy", busy, 0);

    // MULT, then back-to-back issues from the done cycle
    run_op(C_MULT, 32'hFFFF_FFFD, 32'h7, 32'h0, lat);
    rd("mult_lo", C_MFLO, 32'hFFFF_FFEB);
    rd("mult_hi", C_MFHI, 32'hFFFF_FFFF);
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    rd("multu_hi", C_MFHI, 32'hFFFF_FFFE);
    rd("multu_lo", C_MFLO, 32'h0000_0001);
    run_op(C_MULT, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE, lat);
    rd("multmn_hi", C_MFHI, 32'h4000_0000);
    rd("multmn_lo", C_MFLO, 32'h0);

`ifdef ALU_MD_DIV_EN
    run_op(C_DIV, 32'hFFFF_FFF9, 32'h2, 32'h4000_0000, lat);
    rd("div_lo", C_MFLO, 32'hFFFF_FFFD);
    rd("div_hi", C_MFHI, 32'hFFFF_FFFF);
    check("div_div0", div0, 0);
    run_op(C_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, lat);
    rd("divz_lo", C_MFLO, 32'hFFFF_FFFF);
    rd("divz_hi", C_MFHI, 32'h1234);
    check("divz_div0", div0, 1);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234, lat);
    rd("divmn_lo", C_MFLO, 32'h8000_0000);
    rd("divmn_hi", C_MFHI, 32'h0);
    check("divmn_div0", div0, 0);
`else
    a = 32'h7; b = 32'h0; control = C_DIVU; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("nodiv_busy", busy, 0);
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("nodiv_done", cnt_done, 0);
    check("nodiv_busycnt", cnt_busy, 0);
    check("nodiv_div0", div0, 0);
    rd("nodiv_hi", C_MFHI, 32'h4000_0000);
    rd("nodiv_lo", C_MFLO, 32'h0);
`endif

    // Second start at cycle 10 of a run is ignored
    a = 32'h0001_0000; b = 32'h0003_0000; control = C_MULTU; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
    a = 32'd5; b = 32'd5; control = C_MULTU; start = 1'b1;
    lat = -1;
    for (int i = 10; i <= 100; i++) begin
      @(posedge clk); #1; start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check("ign_latency", lat, 32);
    rd("ign_hi", C_MFHI, 32'h3);
    rd("ign_lo", C_MFLO, 32'h0);
    @(posedge clk); #1;
    check("ign_no_rerun", busy, 0);

    // Reset mid-run
    a = 32'hFFFF_FFFF; b = 32'h2; control = C_MULTU; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    rd("mrst_hi", C_MFHI, 32'h0);
    rd("mrst_lo", C_MFLO, 32'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("mrst_nodone", cnt_done, 0);
    check("mrst_nobusy", cnt_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mips_md.md
# alu_mips_md

Parametrised successor to the single-cycle MIPS ALU. It keeps the combinational ALU path (logic, add/sub, shifts, set-less-than) and adds a sequential multiply/divide unit with architectural HI/LO registers, a start/busy/done handshake, and a divide-by-zero flag. It sits in the execute stage. The pipeline control uses `busy` to stall any MFHI/MFLO or any new MULT/DIV issue.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Must be a power of two and at least 8.
- `SHW`, $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a`, `b`  in  WIDTH: operands. `a` is rs / dividend; `b` is rt / divisor.
- `control`  in  5: operation code (see Operation).
- `shift`  in  SHW: shift amount.
- `start`  in  1: launches the MULT/DIV op currently on `control`.
- `outalu`  out  WIDTH: combinational result.
- `zero`  out  1: `outalu` equals 0.
- `ovf`  out  1: signed overflow, ADD/SUB only. 0 for all other ops.
- `busy`  out  1: multiply/divide in progress.
- `done`  out  1: one-cycle pulse when HI/LO are updated.
- `div0`  out  1: registered. Set by a DIV/DIVU with `b`==0; cleared by the next accepted MULT/DIV.

## Operation
Combinational codes (`outalu` is valid in the same cycle):
- 00000 AND
- 00001 OR
- 00010 ADD
- 00110 SUB
- 00111 SLL, `b<<shift`
- 01001 XOR
- 01010 NOR
- 10000 SRL, `b>>shift`
- 10001 SRA, arithmetic `b>>>shift`
- 10010 SLT, signed compare, result 1 or 0
- 10011 SLTU, unsigned compare, result 1 or 0
- 11000 MFHI
- 11001 MFLO

Multi-cycle codes (`outalu` is 0 for these):
- 10100 MULT, 10101 MULTU, 10110 DIV, 10111 DIVU.

Unlisted codes drive `outalu`=0.

Arithmetic rules:
- ADD/SUB wrap modulo 2^WIDTH. `ovf` is the signed overflow of that operation.
- MULT/MULTU produce a 2·WIDTH-bit product: HI gets the upper half, LO the lower half.
- DIV/DIVU: LO=quotient, HI=remainder.
- Signed ops run on operand magnitudes, then fix signs: product negated if the operand signs differ; quotient negated if the operand signs differ; remainder takes the sign of the dividend. Quotient truncates toward zero.
- Divide by zero: LO=all ones, HI=`a` (raw operand), `div0`=1. Applies to both DIV and DIVU.
- Most-negative ÷ −1 (signed): LO=most-negative, HI=0, `div0`=0.

Handshake / state machine, states IDLE → RUN → IDLE:
- `start`=1 with a multi-cycle code in IDLE: operands and op are latched, state goes to RUN.
- `start` while in RUN is ignored. A latched op is unaffected by later changes to `a`, `b` or `control`.
- `start` with a non-multi-cycle code is ignored.
- MFHI/MFLO issued during RUN return the previous HI/LO. Stalling them is the pipeline's responsibility.
- The core is iterative, one bit per cycle, for all four ops.

Reset (`rst_n` low, at any time including mid-operation):
- `busy`=0, `done`=0, `div0`=0.
- HI=0, LO=0.
- State=IDLE.
- The partial result is discarded.

## Timing
- Acceptance edge E0: `busy`=1 from E0.
- Iterations occur on edges E1..E_WIDTH.
- At edge E_WIDTH: HI/LO (and `div0`) are written, `busy`=0, `done`=1 for exactly one cycle.
- `busy` is therefore high for WIDTH cycles. WIDTH=32 gives 32 cycles.
- A new `start` is accepted in the same cycle `done` is high (back-to-back issue).
- MFHI/MFLO read the new value in the cycle `done` is high.
- `zero` and `ovf` are combinational from `outalu` / the operands.

## Configuration
- `ALU_MD_DIV_EN` defined: DIV/DIVU are implemented as above.
- Not defined: no divider hardware. DIV/DIVU `start` is ignored: `busy` stays 0, no `done`, HI/LO unchanged, `div0` tied 0. MULT/MULTU are unaffected.

## Structure
- Package `alu_mips_pkg`: the 5-bit operation-code localparams, the state enum (IDLE, RUN), and the `is_muldiv(control)` helper.
- Sub-module `alu_mips_mdcore`: the iterative shift-add multiplier / restoring divider. It owns the counter, the HI/LO-shaped accumulator and the sign fix-up. The top level holds the combinational ALU, HI/LO, and the handshake.

## Test plan
All vectors use WIDTH=32.
- ADD, a=0x7FFFFFFF, b=1 → `outalu`=0x80000000, `ovf`=1, `zero`=0. SUB, a=b=5 → `outalu`=0, `zero`=1, `ovf`=0.
- b=0x80000000, shift=4: SRA → 0xF8000000; SRL → 0x08000000; SLL → 0.
- a=0xFFFFFFFF, b=1: SLT → 1; SLTU → 0.
- MULT, a=0xFFFFFFFD, b=7, `start` pulse → `busy` for 32 cycles, then `done` pulse. HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO then returns 0xFFFFFFEB.
- DIV, a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x1234, `div0`=1.
- Second `start` at cycle 10 of a run → ignored, result unchanged. `rst_n` pulsed low mid-run → `busy`=0, `done`=0, HI=LO=0 immediately, no `done` afterwards.
